// File: rtl/axis_arb_pkg.sv
// axis_arb_pkg: shared types, constants and header-word helper for the packet arbiter
package axis_arb_pkg;
    typedef enum logic [1:0] {IDLE, HEADER, PASS} arb_state_t;
    localparam logic [7:0] DEF_HEADER_MAGIC = 8'hA5;
    localparam int GRANT_W = 3;
    function automatic logic [15:0] make_header(input logic [7:0] magic, input logic [GRANT_W-1:0] id);
        return {magic, 8'(id)};
    endfunction
endpackage

// File: rtl/axis_packet_arbiter_rr_picker.sv
// rr_picker: round-robin search for the first request after the pointer
module rr_picker import axis_arb_pkg::*; #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GRANT_W-1:0] ptr,
    output logic               found,
    output logic [GRANT_W-1:0] index
);
    logic [NUM_REQ-1:0] rot;
    // rot[k] is the request k+1 positions after the pointer
    assign rot = NUM_REQ'({req, req} >> ({1'b0, ptr} + 4'd1));
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (rot[k]) begin
                found = 1'b1;
                index = GRANT_W'((int'(ptr) + 1 + k) % NUM_REQ);
            end
    end
endmodule

// File: rtl/axis_packet_arbiter.sv
// axis_packet_arbiter: packet-atomic round-robin AXIS mux, each packet prefixed by a source header word
module axis_packet_arbiter import axis_arb_pkg::*; #(
    parameter int         NUM_REQ      = 2,
    parameter int         DATA_WIDTH   = 16,
    parameter logic [7:0] HEADER_MAGIC = axis_arb_pkg::DEF_HEADER_MAGIC
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_REQ-1:0]            s_tvalid,
    input  logic [NUM_REQ-1:0]            s_tlast,
    output logic [NUM_REQ-1:0]            s_tready,
    output logic [DATA_WIDTH-1:0]         m_tdata,
    output logic                          m_tvalid,
    output logic                          m_tlast,
    output logic                          m_tuser,
    input  logic                          m_tready,
    output logic [GRANT_W-1:0]            grant_id,
    output logic                          busy,
    output logic [15:0]                   packet_count
);
    localparam int SW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    arb_state_t state;
    logic [GRANT_W-1:0] ptr, pick;
    logic [DATA_WIDTH-1:0] hdr;
    logic found, hdr_st, pass_st;
    logic [SW-1:0] sel;
    rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (
        .req   (s_tvalid),
        .ptr   (ptr),
        .found (found),
        .index (pick)
    );
    assign sel      = grant_id[SW-1:0];
    assign hdr_st   = state == HEADER;
    assign pass_st  = state == PASS;
    // payload beats pass straight through so the granted source sees adapter backpressure directly
    assign m_tvalid = hdr_st | (pass_st & s_tvalid[sel]);
    assign m_tlast  = pass_st & s_tlast[sel];
    assign m_tuser  = hdr_st;
    assign m_tdata  = hdr_st ? hdr : pass_st ? s_tdata[sel*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign s_tready = pass_st ? NUM_REQ'(m_tready) << sel : '0;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            ptr          <= GRANT_W'(NUM_REQ - 1);
            grant_id     <= '0;
            hdr          <= '0;
            busy         <= 1'b0;
            packet_count <= '0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    state    <= HEADER;
                    grant_id <= pick;
                    hdr      <= make_header(HEADER_MAGIC, pick);
                    busy     <= 1'b1;
                end
                HEADER: if (m_tready) state <= PASS;
                PASS: if (m_tvalid && m_tready && m_tlast) begin
                    state        <= IDLE;
                    ptr          <= grant_id;
                    packet_count <= packet_count + 16'd1;
                    busy         <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
